// File: rtl/div_freq_pkg.sv
// Shared constants and types for the programmable frequency divider.
package div_freq_pkg;

  localparam int unsigned DIV_WIDTH_DEF = 20;
  localparam int unsigned DIV_MIN       = 2;

  typedef logic [DIV_WIDTH_DEF-1:0] div_t;

endpackage

// File: rtl/modulo_contador_terminal.sv
// Terminal counter: runs 0..limit-1 while enabled and flags the wrap cycle.
module modulo_contador_terminal
  import div_freq_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             restart,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    wrap  = en && (cnt_q == limit - WIDTH'(1));
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (wrap) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/modulo_divisor_frequencia_prog.sv
// Runtime-programmable clock divider producing a tick pulse and a square wave.
// Define DIV_FREQ_IMMEDIATE_LOAD_EN to apply valid loads on the next edge instead of at wrap.
module modulo_divisor_frequencia_prog
  import div_freq_pkg::*;
#(
  parameter int unsigned WIDTH     = DIV_WIDTH_DEF,
  parameter int unsigned DIV_RESET = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_value,
  output logic             tick,
  output logic             clk_div,
  output logic [WIDTH-1:0] div_cur,
  output logic             load_pend,
  output logic             load_err
);

  logic [WIDTH-1:0] div_cur_q, div_cur_d;
  logic             tick_q, tick_d;
  logic             clk_div_q, clk_div_d;
  logic             load_err_q, load_err_d;
  logic [WIDTH-1:0] cnt;
  logic             wrap;
  logic             restart;
  logic             load_ok;
  logic [WIDTH-1:0] half_last;

  assign load_ok   = div_load && (div_value >= WIDTH'(DIV_MIN));
  assign half_last = (div_cur_q >> 1) - WIDTH'(1);

`ifdef DIV_FREQ_IMMEDIATE_LOAD_EN
  assign restart = load_ok;
`else
  assign restart = 1'b0;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pend_val_q, pend_val_d;
`endif

  modulo_contador_terminal #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk    (clk),
    .clr    (clr),
    .en     (en),
    .restart(restart),
    .limit  (div_cur_q),
    .cnt    (cnt),
    .wrap   (wrap)
  );

  always_comb begin
    div_cur_d  = div_cur_q;
    tick_d     = wrap;
    clk_div_d  = clk_div_q;
    load_err_d = div_load && !load_ok;
    if (wrap) begin
      clk_div_d = 1'b1;
    end else if (en && (cnt == half_last)) begin
      clk_div_d = 1'b0;
    end
`ifdef DIV_FREQ_IMMEDIATE_LOAD_EN
    if (load_ok) begin
      div_cur_d = div_value;
      tick_d    = 1'b0;
      clk_div_d = 1'b0;
    end
`else
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    // Apply before capturing so a load landing in the wrap cycle waits for the next wrap.
    if (wrap && pend_q) begin
      div_cur_d = pend_val_q;
      pend_d    = 1'b0;
    end
    if (load_ok) begin
      pend_d     = 1'b1;
      pend_val_d = div_value;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      div_cur_q  <= WIDTH'(DIV_RESET);
      tick_q     <= 1'b0;
      clk_div_q  <= 1'b0;
      load_err_q <= 1'b0;
`ifndef DIV_FREQ_IMMEDIATE_LOAD_EN
      pend_q     <= 1'b0;
      pend_val_q <= '0;
`endif
    end else begin
      div_cur_q  <= div_cur_d;
      tick_q     <= tick_d;
      clk_div_q  <= clk_div_d;
      load_err_q <= load_err_d;
`ifndef DIV_FREQ_IMMEDIATE_LOAD_EN
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
`endif
    end
  end

  assign tick     = tick_q;
  assign clk_div  = clk_div_q;
  assign div_cur  = div_cur_q;
  assign load_err = load_err_q;
`ifdef DIV_FREQ_IMMEDIATE_LOAD_EN
  assign load_pend = 1'b0;
`else
  assign load_pend = pend_q;
`endif

endmodule

// File: doc/modulo_divisor_frequencia_prog.md
Name: modulo_divisor_frequencia_prog

Overview:
- Runtime-programmable integer clock divider for the design's timing chain, replacing fixed ripple-T-flip-flop chains with a fully synchronous counter.
- Produces two outputs: a one-cycle enable pulse (tick) for downstream modules, and a near-50% duty square wave (clk_div) for display and LED use.
- The divisor is reloaded glitch-free at the counter wrap point, so consumers never see a truncated or stretched period.

Parameters:
- WIDTH, 20, bit width of the counter and divisor (maximum divisor 2^WIDTH-1).
- DIV_RESET, 2, divisor in force after clr; must be >= 2 and < 2^WIDTH.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- clr  in  1  synchronous active-high reset; highest priority.
- en  in  1  count enable; when 0 the divider freezes.
- div_load  in  1  one-cycle request to load div_value.
- div_value  in  WIDTH  requested divisor N.
- tick  out  1  one-cycle pulse, once per N enabled cycles.
- clk_div  out  1  divided square wave.
- div_cur  out  WIDTH  divisor currently in force.
- load_pend  out  1  a loaded divisor is waiting for the next wrap.
- load_err  out  1  one-cycle pulse: load rejected (div_value < 2).

Behaviour:
- All outputs are registered.
- Reset (clr=1 at a clock edge):
  - cnt=0, div_cur=DIV_RESET, pending register=0, load_pend=0.
  - tick=0, clk_div=0, load_err=0.
  - clr overrides en and div_load in the same cycle; a reset mid-period discards the partial period and any pending load.
- Counting:
  - cnt runs 0..div_cur-1 on each cycle with en=1, then wraps to 0.
  - The wrap cycle is the enabled cycle with cnt==div_cur-1.
  - tick is 1 in the cycle after each wrap cycle, and 0 otherwise.
  - With en held at 1 from clr release, the first tick is high in cycle N+1 (cycle 1 = first edge after clr deasserts), then every N cycles.
- clk_div:
  - Set to 1 on the same edge that raises tick.
  - Cleared on the edge after the enabled cycle where cnt==(N>>1)-1.
  - Result: high for floor(N/2) cycles, low for ceil(N/2) cycles. N=2 gives 1/1; N=5 gives 2 high / 3 low.
- en=0: cnt, clk_div, div_cur and pending state all hold; tick is forced to 0.
- Load handshake:
  - div_load=1 with div_value>=2 captures div_value into the pending register and sets load_pend the next cycle.
  - On the next wrap cycle: div_cur takes the pending value, load_pend clears, and the new period starts from cnt=0.
  - A second valid load while pending overwrites the pending value (last wins).
  - A load arriving in a wrap cycle is not applied at that wrap; it is applied at the following one.
  - div_load with div_value<2: ignored, load_err pulses high for one cycle, and any existing pending value is kept.
- Arithmetic: unsigned compares only; no counter overflow is possible because div_cur < 2^WIDTH.

Optional Feature:
- Macro: DIV_FREQ_IMMEDIATE_LOAD_EN.
- Defined: a valid load is applied on the next edge, independent of en and wrap:
  - div_cur takes div_value, cnt=0, clk_div=0, tick=0.
  - load_pend is tied to 0.
  - The first new tick follows N enabled cycles later.
- Not defined: the deferred-at-wrap behaviour described under Behaviour.
- load_err behaviour is identical in both builds.

Decomposition:
- Shared package div_freq_pkg:
  - Constant DIV_WIDTH_DEF=20.
  - Constant DIV_MIN=2.
  - Typedef div_t (logic [DIV_WIDTH_DEF-1:0]).
- One sub-module, modulo_contador_terminal:
  - Parametrised WIDTH counter with inputs clr, en, restart and limit.
  - Outputs cnt and wrap (cnt==limit-1 && en).
- The top level holds the divisor/pending registers, load control and the tick/clk_div registers.

Test Plan:
- Reset, DIV_RESET=2, en=1 for 10 cycles -> tick high in cycles 3,5,7,9; clk_div toggles each cycle, rising with tick; div_cur=2.
- div_load with div_value=5 mid-period -> load_pend=1 until the wrap; afterwards tick every 5 cycles, clk_div 2 high / 3 low, div_cur=5.
- div_load with 1, then with 0 -> load_err pulses once per request; div_cur and the period are unchanged; load_pend unchanged.
- Loads 7 then 9 while pending -> the next wrap applies 9; tick period becomes 9; load_pend clears.
- N=6, en dropped for 4 cycles mid-period -> cnt and clk_div frozen, no tick; period resumes where it stopped, so the tick is delayed by exactly 4 cycles.
- clr asserted with a load pending, mid-period -> next cycle all outputs are at reset values and the pending load is lost. With DIV_FREQ_IMMEDIATE_LOAD_EN: loading 4 takes effect next edge, and the first tick is 4 enabled cycles later.
